// File: rtl/demux4_dist.sv
// Registered 1-to-4 stream distributor: each accepted word lands in one of four
// single-entry lane registers, chosen by sel (manual) or a round-robin pointer
// that advances every BURST words (auto). Optional broadcast: DEMUX4_BCAST_EN.
module demux4_dist #(
    parameter int N     = 7,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mode,
    input  logic [1:0]   sel,
    input  logic         in_valid,
    input  logic [N:0]   in_data,
    output logic         in_ready,
    output logic [3:0]   out_valid,
    output logic [N:0]   out_data0,
    output logic [N:0]   out_data1,
    output logic [N:0]   out_data2,
    output logic [N:0]   out_data3,
    input  logic [3:0]   out_ready,
`ifdef DEMUX4_BCAST_EN
    input  logic         bcast,
`endif
    output logic [1:0]   lane
);

    localparam int            CW       = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    logic [1:0]    ptr;
    logic [CW-1:0] cnt;
    logic [1:0]    tgt;
    logic [3:0]    free;
    logic [3:0]    load;
    logic          accept;
    logic          bc;

`ifdef DEMUX4_BCAST_EN
    assign bc = bcast;
`else
    assign bc = 1'b0;
`endif

    // A lane is free when empty or when its consumer takes the word this cycle,
    // so a full lane with out_ready high still sustains one word per cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        load     = 4'b0000;
        tgt      = mode ? ptr : sel;
        free     = ~out_valid | out_ready;
        in_ready = bc ? (&free) : free[tgt];
        accept   = in_valid & in_ready;
        if (accept) begin
            load = bc ? 4'b1111 : (4'b0001 << tgt);
        end
    end

    assign lane = tgt;

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 4'b0000;
        end else begin
            out_valid <= load | (out_valid & ~out_ready);
        end
    end

    // NOTE: the lane data registers are reset too, so a freshly reset block shows zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data0 <= '0;
            out_data1 <= '0;
            out_data2 <= '0;
            out_data3 <= '0;
        end else begin
            if (load[0]) out_data0 <= in_data;
            if (load[1]) out_data1 <= in_data;
            if (load[2]) out_data2 <= in_data;
            if (load[3]) out_data3 <= in_data;
        end
    end

    // Manual mode keeps the pointer tracking sel so that entering auto mode
    // starts at the last manual lane with a fresh burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd0;
            cnt <= '0;
        end else if (!mode) begin
            ptr <= sel;
            cnt <= '0;
        end else if (accept && !bc) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                ptr <= ptr + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux4_dist.sv
// Directed bench for demux4_dist: one BURST=4 instance and one BURST=1 instance,
// with broadcast steps enabled when DEMUX4_BCAST_EN is defined.
module tb_demux4_dist;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a_mode, a_in_valid, a_in_ready;
    logic [1:0] a_sel, a_lane;
    logic [7:0] a_in_data, a_d0, a_d1, a_d2, a_d3;
    logic [3:0] a_out_valid, a_out_ready;
    logic       a_bcast;

    logic       b_mode, b_in_valid, b_in_ready;
    logic [1:0] b_sel, b_lane;
    logic [7:0] b_in_data, b_d0, b_d1, b_d2, b_d3;
    logic [3:0] b_out_valid, b_out_ready;
    logic       b_bcast;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demux4_dist #(.N(7), .BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(a_mode), .sel(a_sel),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data0(a_d0), .out_data1(a_d1),
        .out_data2(a_d2), .out_data3(a_d3), .out_ready(a_out_ready),
`ifdef DEMUX4_BCAST_EN
        .bcast(a_bcast),
`endif
        .lane(a_lane)
    );

    demux4_dist #(.N(7), .BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data0(b_d0), .out_data1(b_d1),
        .out_data2(b_d2), .out_data3(b_d3), .out_ready(b_out_ready),
`ifdef DEMUX4_BCAST_EN
        .bcast(b_bcast),
`endif
        .lane(b_lane)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_mode = 1'b0; a_sel = 2'd0; a_in_valid = 1'b0; a_in_data = 8'd0;
        a_out_ready = 4'b0000; a_bcast = 1'b0;
        b_mode = 1'b1; b_sel = 2'd0; b_in_valid = 1'b0; b_in_data = 8'd0;
        b_out_ready = 4'b1011; b_bcast = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(a_out_valid), 32'h0);
        chk("rst_data", {a_d0, a_d1, a_d2, a_d3}, 32'h0);
        chk("rst_lane", 32'(a_lane), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Manual single word to lane 2
        a_sel = 2'd2; a_in_data = 8'd9; a_in_valid = 1'b1; a_out_ready = 4'b1111;
        step();
        a_in_valid = 1'b0;
        chk("man_valid", 32'(a_out_valid), 32'b0100);
        chk("man_data2", 32'(a_d2), 32'd9);
        chk("man_others", {8'd0, a_d0, a_d1, a_d3}, 32'h0);
        step();
        chk("man_drain", 32'(a_out_valid), 32'b0000);

        // Manual stall on lane 1, then release
        a_sel = 2'd1; a_out_ready = 4'b1101; a_in_data = 8'd4; a_in_valid = 1'b1;
        step();
        a_in_data = 8'd5;
        chk("stall_in_ready", 32'(a_in_ready), 32'd0);
        step();
        chk("stall_valid", 32'(a_out_valid), 32'b0010);
        chk("stall_hold4", 32'(a_d1), 32'd4);
        a_out_ready = 4'b1111;
        #1;
        chk("release_in_ready", 32'(a_in_ready), 32'd1);
        step();
        a_in_valid = 1'b0;
        chk("release_valid", 32'(a_out_valid), 32'b0010);
        chk("release_data5", 32'(a_d1), 32'd5);
        step();
        chk("release_drain", 32'(a_out_valid), 32'b0000);

        // Auto mode, BURST=4, 16 back-to-back words from lane 0
        a_sel = 2'd0;
        step();
        a_mode = 1'b1;
        #1;
        chk("auto_start_lane", 32'(a_lane), 32'd0);
        for (int w = 1; w <= 16; w++) begin
            a_in_data = 8'(w);
            a_in_valid = 1'b1;
            step();
            case ((w - 1) / 4)
                0: chk("auto_data_l0", 32'(a_d0), 32'(w));
                1: chk("auto_data_l1", 32'(a_d1), 32'(w));
                2: chk("auto_data_l2", 32'(a_d2), 32'(w));
                default: chk("auto_data_l3", 32'(a_d3), 32'(w));
            endcase
            chk("auto_valid", 32'(a_out_valid), 32'(4'b0001 << ((w - 1) / 4)));
        end
        a_in_valid = 1'b0;
        chk("auto_wrap_lane", 32'(a_lane), 32'd0);
        step();

        // sel=3 manual, switch to auto, two words, then reset mid-stream
        a_mode = 1'b0; a_sel = 2'd3;
        step();
        a_mode = 1'b1;
        a_in_data = 8'd21; a_in_valid = 1'b1;
        step();
        a_in_data = 8'd22;
        step();
        chk("switch_data3", 32'(a_d3), 32'd22);
        chk("switch_valid", 32'(a_out_valid), 32'b1000);
        chk("switch_lane_cnt2", 32'(a_lane), 32'd3);
        a_in_data = 8'd23;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(a_out_valid), 32'b0000);
        chk("midrst_data3", 32'(a_d3), 32'd0);
        a_in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
        chk("midrst_lane", 32'(a_lane), 32'd0);

        // BURST=1, out_ready=1011: lanes cycle every word, lane 2 fills and stalls
        step();
        b_in_valid = 1'b1;
        b_in_data = 8'd31; step();
        chk("b1_w31", {b_out_valid, b_lane, b_d0}, {4'b0001, 2'd1, 8'd31});
        b_in_data = 8'd32; step();
        chk("b1_w32", {b_out_valid, b_lane, b_d1}, {4'b0010, 2'd2, 8'd32});
        b_in_data = 8'd33; step();
        chk("b1_w33", {b_out_valid, b_lane, b_d2}, {4'b0100, 2'd3, 8'd33});
        b_in_data = 8'd34; step();
        chk("b1_w34", {b_out_valid, b_lane, b_d3}, {4'b1100, 2'd0, 8'd34});
        b_in_data = 8'd35; step();
        chk("b1_w35", {b_out_valid, b_lane, b_d0}, {4'b0101, 2'd1, 8'd35});
        b_in_data = 8'd36; step();
        chk("b1_w36", {b_out_valid, b_lane, b_d1}, {4'b0110, 2'd2, 8'd36});
        b_in_data = 8'd37;
        chk("b1_stall_ready", 32'(b_in_ready), 32'd0);
        step();
        chk("b1_stall_hold", {b_out_valid, b_lane, b_d2}, {4'b0100, 2'd2, 8'd33});
        b_out_ready = 4'b1111;
        #1;
        chk("b1_resume_ready", 32'(b_in_ready), 32'd1);
        step();
        b_in_valid = 1'b0;
        chk("b1_resume_w37", {b_out_valid, b_lane, b_d2}, {4'b0100, 2'd3, 8'd37});

`ifdef DEMUX4_BCAST_EN
        // Broadcast leaves ptr/cnt alone: one unicast word, a broadcast, then 3 more
        a_mode = 1'b1; a_out_ready = 4'b1111;
        a_in_data = 8'd40; a_in_valid = 1'b1;
        step();
        a_bcast = 1'b1; a_in_data = 8'd15;
        step();
        a_bcast = 1'b0; a_in_valid = 1'b0;
        chk("bc_valid", 32'(a_out_valid), 32'b1111);
        chk("bc_data", {a_d0, a_d1, a_d2, a_d3}, 32'h0f0f0f0f);
        chk("bc_lane", 32'(a_lane), 32'd0);
        a_in_valid = 1'b1;
        a_in_data = 8'd41; step();
        a_in_data = 8'd42; step();
        chk("bc_cnt_kept_lane0", 32'(a_lane), 32'd0);
        a_in_data = 8'd43; step();
        chk("bc_cnt_kept_lane1", 32'(a_lane), 32'd1);
        a_out_ready = 4'b0000; a_in_data = 8'd44;
        step();
        a_bcast = 1'b1;
        #1;
        chk("bc_full_in_ready", 32'(a_in_ready), 32'd0);
        a_bcast = 1'b0; a_in_valid = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux4_dist.md
# demux4_dist

Registered 1-to-4 stream distributor for the CNN processor datapath: each accepted word goes into exactly one of four lane output registers, one per processing-element input buffer. It is the return-side counterpart of the `mux4` lane selector. Lane choice comes from an external `sel` in manual mode, or from an internal round-robin pointer that advances every `BURST` words in auto mode. A valid/ready handshake runs on the input side and on every lane.

## Interface
- `N`, default 7: data MSB index; all data buses are `[N:0]`.
- `BURST`, default 4: words sent to a lane before the auto pointer advances; legal range 1..256.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = manual (`sel` chooses the lane), 1 = auto round-robin.
- `sel`  in  2  target lane in manual mode; ignored in auto mode.
- `in_valid`  in  1  input word present.
- `in_data`  in  N+1  input word.
- `in_ready`  out  1  input word will be accepted this cycle.
- `out_valid`  out  4  bit i = lane i register holds a word.
- `out_data0`..`out_data3`  out  N+1 each  lane register contents.
- `out_ready`  in  4  bit i = lane i consumer takes its word this cycle.
- `lane`  out  2  current target lane: `sel` in manual mode, the pointer in auto mode.
- `bcast`  in  1  present only when `DEMUX4_BCAST_EN` is defined.

## Operation
- Target lane T = `sel` when `mode`=0, otherwise the pointer `ptr`.
- Each lane is a single-entry register.
  - It is free when `out_valid[i]`=0, or when `out_valid[i]`=1 and `out_ready[i]`=1 in the same cycle.
- `in_ready` = lane T free. It is combinational from `mode`, `sel`, `ptr`, `out_valid` and `out_ready`.
- Accept = `in_valid` & `in_ready`. On accept: `out_dataT` <= `in_data` and `out_valid[T]` <= 1.
- Drain: `out_valid[i]` & `out_ready[i]` with no load into lane i that cycle gives `out_valid[i]` <= 0. `out_data` holds its last value.
- Simultaneous drain and load on the same lane: the new word replaces the old one and `out_valid` stays 1, so lane throughput is one word per cycle.
- Lanes other than T drain independently. Every lane holds its word while its `out_ready` is low.
- Auto counter `cnt` ranges 0..BURST-1.
  - On an auto-mode accept: if `cnt`=BURST-1 then `cnt`<=0 and `ptr`<=`ptr`+1 (wrapping 3->0); otherwise `cnt`<=`cnt`+1.
  - With BURST=1 the pointer advances on every word.
- Manual mode, every cycle: `ptr`<=`sel` and `cnt`<=0. Switching to auto therefore starts at the last `sel` with a fresh burst.
- Arithmetic: `ptr` is 2 bits with natural wrap. `cnt` is wide enough for BURST-1; it never exceeds BURST-1.

## Timing
- Latency: a word accepted in cycle k appears on `out_dataT` with `out_valid[T]`=1 in cycle k+1.
- Input handshake: the sender holds `in_data` stable while `in_valid`=1 and `in_ready`=0.
- Lane handshake: a word leaves lane i in the cycle where `out_valid[i]` and `out_ready[i]` are both high.
- Reset (asynchronous assertion, synchronous-safe release):
  - `out_valid`=0, all `out_data`=0, `ptr`=0, `cnt`=0.
  - `in_ready` then follows `mode`/`sel`: it is 1 after reset because all lanes are empty.
- Reset mid-operation discards all held words; no partial handshake completes.
- A change of `mode` or `sel` while stalled retargets immediately. The stalled input word goes to the new T, and no word is lost or duplicated.

## Configuration
- `DEMUX4_BCAST_EN` defined:
  - Adds the `bcast` input.
  - While `bcast`=1, `in_ready` = all four lanes free, and an accept loads `in_data` into all four lanes with `out_valid`=4'b1111.
  - Broadcast accepts do not change `cnt` or `ptr`.
- `DEMUX4_BCAST_EN` undefined: no `bcast` port and unicast behaviour only. The hardware matches the `bcast`=0 case above.

## Test plan
- Reset, then manual mode with `sel`=2, `in_data`=8'd9 and `out_ready`=4'b1111 -> next cycle `out_valid`=4'b0100, `out_data2`=9; the other lanes stay 0.
- Manual mode, `sel`=1, `out_ready[1]`=0, two words 8'd4 then 8'd5 -> the first is accepted; then `in_ready`=0, `out_data1` holds 4 and 5 stays offered. Raising `out_ready[1]` -> 5 is accepted in that same cycle and appears next cycle.
- Auto mode, BURST=4, all ready, 16 back-to-back words 1..16 -> lane 0 receives 1-4, lane 1 receives 5-8, lane 2 receives 9-12, lane 3 receives 13-16; `lane` then reads 0 (wrap).
- `sel`=3 in manual mode, switch to auto, 2 words -> both go to lane 3 and `cnt`=2. Then assert `rst_n`=0 mid-stream -> `out_valid`=0, `lane`=0 after release.
- Auto mode, BURST=1, with `out_ready`=4'b1011 -> words go to lanes 0, 1, then stall at lane 2 after it fills. Releasing `out_ready[2]` resumes the flow with no loss.
- With `DEMUX4_BCAST_EN` and `bcast`=1, `in_data`=8'd15 -> all four lanes = 15 and `out_valid`=4'b1111, with `ptr` and `cnt` unchanged. With any lane held full, `in_ready`=0.
